// File: rtl/dvp_pkg.sv
// Shared constants and types for the DVP self-test pattern source.
package dvp_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_TOTAL_DEF  = 784;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BACK_DEF   = 17;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 510;

  // RGB565 bar colours, entry 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dvp_tx_pixgen.sv
// Pixel colour lookup: colour bars, or a coordinate gradient when DVP_TX_GRADIENT_EN is defined.
module dvp_tx_pixgen
  import dvp_pkg::*;
(
  input  logic [2:0]  bar_i,
`ifdef DVP_TX_GRADIENT_EN
  input  logic [5:0]  h_i,
  input  logic [4:0]  v_i,
  input  logic [4:0]  frame_i,
  input  logic        pattern_i,
`endif
  output logic [15:0] pix_o
);

  always_comb begin
    pix_o = BAR_RGB[bar_i];
`ifdef DVP_TX_GRADIENT_EN
    if (pattern_i) pix_o = {v_i, h_i, frame_i};
`endif
  end

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP test-pattern source (RGB565, high byte first); frames run back to back while en is high.
// Optional gradient pattern compiled in with DVP_TX_GRADIENT_EN.
module dvp_pattern_tx
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BACK   = V_BACK_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       pattern_sel,
  output logic       dvp_pclk,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW    = 12;
  localparam int BAR_W = H_ACTIVE / 8;

  state_e          state_q, state_d;
  logic            phase_q, byte_q, byte_d;
  logic [CW-1:0]   h_q, h_d, v_q, v_d, bar_px_q, bar_px_d;
  logic [2:0]      bar_q, bar_d;
  logic            vsync_q, vsync_d, href_q, href_d, done_q, done_d;
  logic [7:0]      data_q, data_d;
  logic            fall, last_pos, start, adv, run_n;
  logic [15:0]     pix;

  // Every DVP output moves on the clk where pclk drops, so it is stable at pclk rise.
  assign fall     = phase_q;
  assign last_pos = (v_q == CW'(V_TOTAL - 1)) && (h_q == CW'(H_TOTAL - 1)) && byte_q;
  assign run_n    = start || adv;

`ifdef DVP_TX_GRADIENT_EN
  logic       pat_q, pat_d;
  logic [4:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      pat_q <= pat_d;
      if (done_d) frame_q <= frame_q + 5'd1;
    end
  end

  assign pat_d = start ? pattern_sel : pat_q;

  dvp_tx_pixgen u_pixgen (
    .bar_i     (bar_d),
    .h_i       (h_d[5:0]),
    .v_i       (v_d[4:0]),
    .frame_i   (frame_q),
    .pattern_i (pat_d),
    .pix_o     (pix)
  );
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;

  dvp_tx_pixgen u_pixgen (
    .bar_i (bar_d),
    .pix_o (pix)
  );
`endif

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    start    = 1'b0;
    adv      = 1'b0;
    byte_d   = byte_q;
    h_d      = h_q;
    v_d      = v_q;
    bar_d    = bar_q;
    bar_px_d = bar_px_q;
    if (fall) begin
      case (state_q)
        ST_IDLE: if (en) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end
        ST_RUN: if (last_pos) begin
          done_d = 1'b1;
          if (en) start = 1'b1;
          else    state_d = ST_IDLE;
        end else begin
          adv = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (adv) begin
      byte_d = ~byte_q;
      if (byte_q) begin
        if (h_q == CW'(H_TOTAL - 1)) begin
          h_d      = '0;
          v_d      = v_q + 1'b1;
          bar_d    = '0;
          bar_px_d = '0;
        end else begin
          h_d = h_q + 1'b1;
          // Bar index stepped by a pixel counter rather than dividing h_cnt.
          if (bar_px_q == CW'(BAR_W - 1)) begin
            bar_px_d = '0;
            bar_d    = bar_q + 3'd1;
          end else begin
            bar_px_d = bar_px_q + 1'b1;
          end
        end
      end
    end else if (fall) begin
      byte_d   = 1'b0;
      h_d      = '0;
      v_d      = '0;
      bar_d    = '0;
      bar_px_d = '0;
    end
  end

  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    data_d  = data_q;
    if (fall) begin
      vsync_d = run_n && (v_d < CW'(V_SYNC));
      href_d  = run_n && (v_d >= CW'(V_SYNC + V_BACK)) &&
                (v_d < CW'(V_SYNC + V_BACK + V_ACTIVE)) && (h_d < CW'(H_ACTIVE));
      data_d  = 8'h00;
      if (href_d) data_d = byte_d ? pix[7:0] : pix[15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= 1'b0;
      byte_q   <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      bar_q    <= '0;
      bar_px_q <= '0;
      vsync_q  <= 1'b0;
      href_q   <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= ~phase_q;
      byte_q   <= byte_d;
      h_q      <= h_d;
      v_q      <= v_d;
      bar_q    <= bar_d;
      bar_px_q <= bar_px_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  assign dvp_pclk   = phase_q;
  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_data   = data_q;
  assign busy       = (state_q == ST_RUN);
  assign frame_done = done_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx: expected byte stream built per frame from raster arithmetic.
module tb_dvp_pattern_tx;

  localparam int H_ACTIVE  = 16;
  localparam int H_TOTAL   = 20;
  localparam int V_SYNC    = 1;
  localparam int V_BACK    = 1;
  localparam int V_ACTIVE  = 4;
  localparam int V_TOTAL   = 8;
  localparam int FRAME_CLK = V_TOTAL * H_TOTAL * 4;
`ifdef DVP_TX_GRADIENT_EN
  localparam bit GRAD = 1'b1;
`else
  localparam bit GRAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, pattern_sel;
  logic       dvp_pclk, dvp_vsync, dvp_href, busy, frame_done;
  logic [7:0] dvp_data;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [4:0] fc = '0;

  dvp_pattern_tx #(
    .H_ACTIVE (H_ACTIVE), .H_TOTAL (H_TOTAL), .V_SYNC (V_SYNC),
    .V_BACK   (V_BACK),   .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .dvp_pclk    (dvp_pclk),
    .dvp_vsync   (dvp_vsync),
    .dvp_href    (dvp_href),
    .dvp_data    (dvp_data),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] bar_rgb(input int i);
    case (i)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected bytes of one whole frame, in transmission order.
  task automatic push_frame(input bit pat);
    logic [15:0] pix;
    bit          act;
    for (int ln = 0; ln < V_TOTAL; ln++) begin
      for (int px = 0; px < H_TOTAL; px++) begin
        act = (ln >= V_SYNC + V_BACK) && (ln < V_SYNC + V_BACK + V_ACTIVE) && (px < H_ACTIVE);
        pix = bar_rgb(px / (H_ACTIVE / 8));
        if (pat && GRAD) pix = {5'(ln), 6'(px), fc};
        exp_q.push_back('{vs: (ln < V_SYNC), hr: act, d: act ? pix[15:8] : 8'h00});
        exp_q.push_back('{vs: (ln < V_SYNC), hr: act, d: act ? pix[7:0]  : 8'h00});
      end
    end
    fc = fc + 5'd1;
  endtask

  // Monitor: one byte per pclk high phase.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && dvp_pclk) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {dvp_vsync, dvp_href, dvp_data}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("dvp_byte", {dvp_vsync, dvp_href, dvp_data}, {e.vs, e.hr, e.d});
        end
      end else begin
        chk("idle_outputs", {dvp_vsync, dvp_href, dvp_data}, 32'h0);
      end
    end
  end

  // Frame-level timing: period, vsync width and line count.
  int cyc = 0, start_cyc = 0, vs_clks = 0, href_rises = 0;
  bit started = 0, vs_prev = 0, hr_prev = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      started = 0;
      vs_prev = 0;
      hr_prev = 0;
    end else begin
      if (frame_done && started) begin
        chk("frame_period_clk", cyc - start_cyc, FRAME_CLK);
        chk("vsync_high_clk", vs_clks, V_SYNC * H_TOTAL * 4);
        chk("href_pulses", href_rises, V_ACTIVE);
        started = 0;
      end
      if (dvp_vsync && !vs_prev) begin
        started    = 1;
        start_cyc  = cyc;
        vs_clks    = 0;
        href_rises = 0;
      end
      if (dvp_vsync) vs_clks++;
      if (dvp_href && !hr_prev) href_rises++;
      vs_prev = dvp_vsync;
      hr_prev = dvp_href;
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_pclk"},  dvp_pclk, 0);
    chk({nm, "_vsync"}, dvp_vsync, 0);
    chk({nm, "_href"},  dvp_href, 0);
    chk({nm, "_data"},  dvp_data, 0);
    chk({nm, "_busy"},  busy, 0);
    chk({nm, "_done"},  frame_done, 0);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < FRAME_CLK + 20);
    chk("frame_done_seen", frame_done, 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    chk("busy_after_stop", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic run_frames(input int nf, input int drop_off, input bit pat);
    pattern_sel = pat;
    repeat (nf) push_frame(pat);
    en = 1'b1;
    wait_busy();
    repeat ((nf - 1) * FRAME_CLK + drop_off) @(posedge clk);
    #1;
    en = 1'b0;
    pattern_sel = ~pat;
    wait_done();
    settle();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    en = 1'b1;
    pattern_sel = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    push_frame(1'b0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dvp_vsync && n < 10);
    vectors++;
    if (n < 1 || n > 3) begin
      miscompares++;
      $display("FAIL vsync_start_latency: got %0d clk expected 1..3", n);
    end
    // Drop en 100 clk into the frame: it must still complete.
    repeat (100) @(posedge clk);
    #1;
    en = 1'b0;
    wait_done();
    settle();

    for (int r = 0; r < 4; r++) begin
      run_frames((r == 0) ? 3 : 1 + int'($urandom_range(2)),
                 5 + int'($urandom_range(590)), 1'($urandom));
    end

    // Asynchronous reset in the middle of a line.
    pattern_sel = 1'($urandom);
    push_frame(pattern_sel);
    en = 1'b1;
    wait_busy();
    repeat (200 + int'($urandom_range(300))) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    fc = '0;
    #1;
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    push_frame(pattern_sel);
    rst_n = 1'b1;
    wait_busy();
    repeat (100) @(posedge clk);
    #1;
    en = 1'b0;
    wait_done();
    settle();

    run_frames(2, 5 + int'($urandom_range(590)), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
